// File: rtl/mux_rr_arbiter_if.sv
// mux_rr_arbiter_if: requester/consumer bundle for mux_rr_arbiter
//   req_valid[N]   requester i has a beat
//   req_data[N*W]  requester i data at [i*W +: W]
//   req_ready[N]   beat from requester i accepted this cycle
//   out_valid      output register holds a beat
//   out_data[W]    output beat
//   out_ready      consumer accepts out_data this cycle
//   out_sel[SW]    index of the granted requester
//   busy           arbiter is in GRANT
interface mux_rr_arbiter_if #(
  parameter int N = 4,
  parameter int W = 8
);
  localparam int SW = $clog2(N);
  logic [N-1:0]   req_valid;
  logic [N*W-1:0] req_data;
  logic [N-1:0]   req_ready;
  logic           out_valid;
  logic [W-1:0]   out_data;
  logic           out_ready;
  logic [SW-1:0]  out_sel;
  logic           busy;
  modport slave (
    input  req_valid, req_data, out_ready,
    output req_ready, out_valid, out_data, out_sel, busy
  );
  modport master (
    output req_valid, req_data, out_ready,
    input  req_ready, out_valid, out_data, out_sel, busy
  );
endinterface

// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: N:1 round-robin burst arbiter with a registered valid/ready output stage
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    mux_rr_arbiter_if.slave: requester handshakes in, registered output channel,
//          current select and busy flag out
module mux_rr_arbiter #(
  parameter int N         = 4,
  parameter int W         = 8,
  parameter int MAX_BURST = 4,
  localparam int SW       = $clog2(N),
  localparam int CW       = $clog2(MAX_BURST + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  mux_rr_arbiter_if.slave    bus
);
  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;
  logic [0:0]    state_q, state_d;
  logic [SW-1:0] sel_q, sel_d, last_q, last_d, win;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          out_valid_q, out_valid_d;
  logic [W-1:0]  out_data_q, out_data_d;
  logic          grant, accept, sel_valid, xfer;
  // Scan from the farthest offset down so the nearest requester after last_q wins.
  always_comb begin
    win = last_q;
    for (int k = N; k >= 1; k--)
      if (bus.req_valid[SW'((int'(last_q) + k) % N)]) win = SW'((int'(last_q) + k) % N);
  end
  assign grant     = state_q == GRANT;
  assign accept    = !out_valid_q || bus.out_ready;
  assign sel_valid = bus.req_valid[sel_q];
  assign xfer      = grant && sel_valid && accept;
  always_comb begin
    state_d     = state_q;
    sel_d       = sel_q;
    last_d      = last_q;
    cnt_d       = cnt_q;
    out_valid_d = xfer ? 1'b1 : (accept ? 1'b0 : out_valid_q);
    out_data_d  = xfer ? bus.req_data[sel_q*W +: W] : out_data_q;
    if (!grant) begin
      if (|bus.req_valid) begin
        state_d = GRANT;
        sel_d   = win;
        cnt_d   = '0;
      end
    end else if (accept && (!sel_valid || cnt_q == CW'(MAX_BURST - 1))) begin
      // Release only when the slot can move: a low valid under backpressure keeps the grant.
      state_d = IDLE;
      last_d  = sel_q;
    end else if (xfer) begin
      cnt_d = cnt_q + 1'b1;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      sel_q       <= '0;
      last_q      <= SW'(N - 1);
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      sel_q       <= sel_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end
  assign bus.req_ready = (grant && accept) ? (N'(1) << sel_q) : '0;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_sel   = sel_q;
  assign bus.busy      = grant;
endmodule
